req_encoder_8to3: RTL and testbench

Registered 8-to-3 encoder with a valid/ready handshake. It collapses eight single-bit event lines into a stream of 3-bit indices, one per accepted transfer. Typical events are per-core "nonce found" strobes from the hash cores, and the consumer is the control logic that reads the winning core's register. Events arriving while the output is stalled are held in a sticky pending mask, so no event is lost. Repeated events on the same line coalesce until that line is granted.

---
 rtl/req_encoder_8to3.sv | 97 +++++++++
 tb/tb_req_encoder_8to3.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/req_encoder_8to3.sv
// rtl/req_encoder_8to3.sv - registered 8-to-3 event encoder with valid/ready output and sticky pending mask
// Optional macro REQ_ENCODER_ROUND_ROBIN_EN selects rotating priority; default build uses fixed lowest-bit priority.
module req_encoder_8to3 (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       ready,
    output logic       valid,
    output logic [2:0] index,
    output logic [7:0] pending
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] pend, pend_nxt;
    logic [2:0] idx, idx_nxt;
    logic [2:0] last, last_nxt;
    logic [7:0] cand;
    logic       free;
    logic [2:0] grant;
    logic       found;

    assign free = (state == EMPTY) || ready;
    // Same-cycle strobes compete alongside held events.
    assign cand = pend | req;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    logic [2:0] rr_pos;

    always_comb begin
        grant  = 3'd0;
        found  = 1'b0;
        rr_pos = 3'd0;
        for (int k = 0; k < 8; k++) begin
            // 3-bit addition wraps 7 -> 0 naturally.
            rr_pos = last + 3'd1 + 3'(k);
            if (!found && cand[rr_pos]) begin
                grant = rr_pos;
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        grant = 3'd0;
        found = |cand;
        for (int k = 7; k >= 0; k--) begin
            if (cand[k]) begin
                grant = 3'(k);
            end
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        idx_nxt   = idx;
        last_nxt  = last;
        if (free) begin
            if (found) begin
                state_nxt = FULL;
                idx_nxt   = grant;
                last_nxt  = grant;
                // A strobe on the granted line this cycle is absorbed by the grant.
                pend_nxt  = cand & ~(8'd1 << grant);
            end else begin
                state_nxt = EMPTY;
            end
        end else begin
            pend_nxt = pend | req;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
            pend  <= 8'h00;
            idx   <= 3'd0;
            last  <= 3'd7;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            idx   <= idx_nxt;
            last  <= last_nxt;
        end
    end

    assign valid   = (state == FULL);
    assign index   = idx;
    assign pending = pend;

endmodule

// File: tb/tb_req_encoder_8to3.sv
// tb/tb_req_encoder_8to3.sv - self-checking bench for req_encoder_8to3 (vector table, corner sequences, random vs model)
module tb_req_encoder_8to3;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       ready;
    logic       valid;
    logic [2:0] index;
    logic [7:0] pending;

    int checks = 0;
    int errors = 0;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    req_encoder_8to3 dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .ready   (ready),
        .valid   (valid),
        .index   (index),
        .pending (pending)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         rst;
        logic [7:0] rq;
        bit         rdy;
        bit         ev;
        logic [2:0] ei;
        logic [7:0] ep;
    } vec_t;

    vec_t vecs[$];

    // reference model state
    bit         mv;
    int         mi;
    int         ml;
    logic [7:0] mp;

    function automatic void add(bit r, logic [7:0] q, bit y, bit ev, logic [2:0] ei, logic [7:0] ep);
        vec_t v;
        v.rst = r; v.rq = q; v.rdy = y; v.ev = ev; v.ei = ei; v.ep = ep;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int step, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic step(bit r, logic [7:0] q, bit y);
        reset = r;
        req   = q;
        ready = y;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic model_step(bit r, logic [7:0] q, bit y);
        logic [7:0] c;
        int g;
        int i;
        if (r) begin
            mv = 1'b0; mi = 0; mp = 8'h00; ml = 7;
        end else if (!mv || y) begin
            c = mp | q;
            if (c == 8'h00) begin
                mv = 1'b0;
            end else begin
                g = -1;
                for (int k = 1; k <= 8; k++) begin
                    i = RR ? (ml + k) % 8 : k - 1;
                    if (g < 0 && c[i]) g = i;
                end
                mv = 1'b1; mi = g; ml = g;
                c[g] = 1'b0;
                mp = c;
            end
        end else begin
            mp = mp | q;
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 8'h00;
        ready = 1'b0;

        // reset and idle
        add(1, 8'hFF, 0, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0, 8'h00);
        add(0, 8'h00, 1, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0, 8'h00);
        // single event latency
        add(0, 8'h20, 1, 1, 5, 8'h00);
        add(0, 8'h00, 1, 0, 0, 8'h00);
        // burst under stall, from a fresh reset
        add(1, 8'h00, 0, 0, 0, 8'h00);
        add(0, 8'h91, 0, 1, 0, 8'h90);
        add(0, 8'h00, 0, 1, 0, 8'h90);
        add(0, 8'h00, 1, 1, 4, 8'h80);
        add(0, 8'h00, 1, 1, 7, 8'h00);
        add(0, 8'h00, 1, 0, 0, 8'h00);
        // fairness with req=03 held
        add(0, 8'h03, 1, 1, 0, RR ? 8'h02 : 8'h02);
        add(0, 8'h03, 1, 1, RR ? 3'd1 : 3'd0, RR ? 8'h01 : 8'h02);
        add(0, 8'h03, 1, 1, 0, 8'h02);
        add(0, 8'h03, 1, 1, RR ? 3'd1 : 3'd0, RR ? 8'h01 : 8'h02);
        add(0, 8'h00, 1, 1, RR ? 3'd0 : 3'd1, 8'h00);
        add(0, 8'h00, 1, 0, 0, 8'h00);
        // coalescing and re-arm
        add(1, 8'h00, 0, 0, 0, 8'h00);
        add(0, 8'h04, 0, 1, 2, 8'h00);
        add(0, 8'h08, 0, 1, 2, 8'h08);
        add(0, 8'h00, 0, 1, 2, 8'h08);
        add(0, 8'h08, 0, 1, 2, 8'h08);
        add(0, 8'h00, 0, 1, 2, 8'h08);
        add(0, 8'h08, 0, 1, 2, 8'h08);
        add(0, 8'h04, 0, 1, 2, 8'h0C);
        add(0, 8'h00, 1, 1, RR ? 3'd3 : 3'd2, RR ? 8'h04 : 8'h08);
        add(0, 8'h00, 1, 1, RR ? 3'd2 : 3'd3, 8'h00);
        add(0, 8'h00, 1, 0, 0, 8'h00);
        // mid-operation reset
        add(1, 8'h00, 0, 0, 0, 8'h00);
        add(0, 8'h01, 0, 1, 0, 8'h00);
        add(0, 8'hF0, 0, 1, 0, 8'hF0);
        add(1, 8'h00, 0, 0, 0, 8'h00);
        add(0, 8'h00, 1, 0, 0, 8'h00);
        add(0, 8'h00, 1, 0, 0, 8'h00);

        foreach (vecs[n]) begin
            step(vecs[n].rst, vecs[n].rq, vecs[n].rdy);
            chk("vec_valid", n, 32'(valid), 32'(vecs[n].ev));
            chk("vec_pending", n, 32'(pending), 32'(vecs[n].ep));
            if (vecs[n].ev) chk("vec_index", n, 32'(index), 32'(vecs[n].ei));
        end

        // randomized traffic against the reference model
        model_step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] q;
            bit r;
            bit y;
            if ($urandom_range(0, 3) == 0)      q = 8'($urandom);
            else if ($urandom_range(0, 1) == 1) q = 8'(1 << $urandom_range(0, 7));
            else                                q = 8'h00;
            y = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 199) == 0);
            model_step(r, q, y);
            step(r, q, y);
            chk("rnd_valid", n, 32'(valid), 32'(mv));
            chk("rnd_pending", n, 32'(pending), 32'(mp));
            if (mv) chk("rnd_index", n, 32'(index), 32'(mi));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
